// File: rtl/ram_bus_bridge.sv
// Bridges a valid/ready CPU memory bus onto a 1024x32 single-port block RAM
// with a one-cycle read pipeline; partial writes are handled as read-modify-write.
module ram_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_ce,
  output logic        ram_oce,
  output logic        ram_reset,
  output logic        ram_wre,
  output logic [9:0]  ram_ad,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RMW_WR,
    ACK
  } state_e;

  state_e      state_q, state_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        ram_ce_q, ram_ce_d;
  logic        ram_wre_q, ram_wre_d;
  logic [9:0]  ram_ad_q, ram_ad_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic hit;
  logic unused_addr_lsbs;

  assign hit              = (mem_addr[31:12] == BASE_ADDR[31:12]);
  assign unused_addr_lsbs = &{1'b0, mem_addr[1:0]};

  always_comb begin
    // NOTE: every next-state value gets a default before the case statement,
    // so no path through this block leaves a signal unassigned (no latches).
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ram_ce_d    = ram_ce_q;
    ram_wre_d   = ram_wre_q;
    ram_ad_d    = ram_ad_q;
    ram_din_d   = ram_din_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (mem_valid && hit) begin
          ram_ad_d = mem_addr[11:2];
          wdata_d  = mem_wdata;
          wstrb_d  = mem_wstrb;
          ram_ce_d = 1'b1;
          if (mem_wstrb == 4'hF) begin
            ram_wre_d = 1'b1;
            ram_din_d = mem_wdata;
            state_d   = WR_REQ;
          end else begin
            // Reads and partial writes both start by fetching the old word.
            ram_wre_d = 1'b0;
            state_d   = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        ram_ce_d = 1'b0;
        state_d  = RD_WAIT;
      end

      RD_WAIT: begin
        if (wstrb_q == 4'h0) begin
          mem_rdata_d = ram_dout;
          mem_ready_d = 1'b1;
          state_d     = ACK;
        end else begin
          for (int i = 0; i < 4; i++) begin
            ram_din_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
          end
          ram_ce_d  = 1'b1;
          ram_wre_d = 1'b1;
          state_d   = RMW_WR;
        end
      end

      WR_REQ, RMW_WR: begin
        ram_ce_d    = 1'b0;
        ram_wre_d   = 1'b0;
        mem_ready_d = 1'b1;
        state_d     = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      ram_ce_q    <= 1'b0;
      ram_wre_q   <= 1'b0;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_wre_q   <= ram_wre_d;
      ram_ad_q    <= ram_ad_d;
      ram_din_q   <= ram_din_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_ce    = ram_ce_q;
  assign ram_wre   = ram_wre_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = ~resetn;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Bench for ram_bus_bridge: behavioural RAM, transaction-level reference model,
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_ram_bus_bridge;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_ce;
  logic        ram_oce;
  logic        ram_reset;
  logic        ram_wre;
  logic [9:0]  ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  ram_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block RAM environment: read-first, output valid after the address edge.
  logic [31:0] ram    [1024];
  logic [31:0] shadow [1024];

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ram[ram_ad] <= ram_din;
      ram_dout <= ram[ram_ad];
    end
  end

  // Reference model: expected completions and expected RAM writes, in order.
  typedef struct { int at_cyc; logic [31:0] rdata; } done_t;
  typedef struct { logic [9:0] ad; logic [31:0] din; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];

  int          cyc = 0;
  logic [31:0] model_rdata = '0;
  logic [31:0] tail_rdata  = '0;
  int          ce_cycles   = 0;
  int          ready_cnt   = 0;
  int          last_ready_cyc;
  logic [31:0] last_ready_data;
  logic [9:0]  last_wr_ad;
  logic [31:0] last_wr_din;
  int          obs_lat;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: outputs are sampled mid-cycle, after edge number cyc.
  always @(negedge clk) begin
    logic exp_rdy;
    check("ram_oce", ram_oce, 1'b1);
    check("ram_reset", ram_reset, !resetn);
    if (!resetn) begin
      done_q.delete();
      model_rdata = '0;
      check("rst_mem_ready", mem_ready, 1'b0);
      check("rst_mem_rdata", mem_rdata, 32'h0);
    end else begin
      exp_rdy = (done_q.size() > 0) && (done_q[0].at_cyc == cyc);
      if (exp_rdy) begin
        model_rdata = done_q[0].rdata;
        void'(done_q.pop_front());
      end
      check("mem_ready", mem_ready, exp_rdy);
      check("mem_rdata", mem_rdata, model_rdata);
      if (mem_ready) begin
        ready_cnt++;
        last_ready_cyc  = cyc;
        last_ready_data = mem_rdata;
      end
    end
    if (ram_ce) ce_cycles++;
    if (ram_ce && ram_wre) begin
      last_wr_ad  = ram_ad;
      last_wr_din = ram_din;
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ram_write: unexpected write ad=%h din=%h, expected none", ram_ad, ram_din);
      end else begin
        check("ram_ad_wr", ram_ad, wr_q[0].ad);
        check("ram_din_wr", ram_din, wr_q[0].din);
        void'(wr_q.pop_front());
      end
    end
  end

  // One CPU transaction to a hit address; entered and left at a falling edge.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input bit hold);
    int          c;
    int          lat;
    logic [9:0]  w;
    logic [31:0] m;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    c = cyc + 1;
    w = addr[11:2];
    last_ready_cyc = -1000;
    if (wstrb == 4'h0) begin
      lat = 2;
      tail_rdata = shadow[w];
    end else if (wstrb == 4'hF) begin
      lat = 1;
      shadow[w] = wdata;
      wr_q.push_back('{w, wdata});
    end else begin
      lat = 3;
      m = shadow[w];
      for (int b = 0; b < 4; b++) if (wstrb[b]) m[8*b +: 8] = wdata[8*b +: 8];
      shadow[w] = m;
      wr_q.push_back('{w, m});
    end
    done_q.push_back('{c + lat, tail_rdata});
    @(posedge clk);
    #1;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    mem_wstrb = 4'($urandom);
    mem_valid = hold;
    repeat (lat + 1) @(posedge clk);
    @(negedge clk);
    obs_lat = last_ready_cyc - c;
  endtask

  task automatic miss(input logic [31:0] addr, input int n);
    int ce0;
    ce0 = ce_cycles;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = $urandom;
    mem_wstrb = 4'($urandom);
    repeat (n) @(negedge clk);
    mem_valid = 1'b0;
    check("miss_no_ce", ce_cycles - ce0, 0);
  endtask

  initial begin
    int rc0;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      ram[i]   <= v;
      shadow[i] = v;
    end
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_ce", ram_ce, 1'b0);
    check("rst_ram_wre", ram_wre, 1'b0);
    check("rst_ram_ad", ram_ad, 10'h0);
    check("rst_ram_din", ram_din, 32'h0);
    resetn = 1'b1;

    // Full write, readback, partial write, readback.
    txn(BASE + 32'h010, 32'hDEADBEEF, 4'hF, 1'b0);
    check("fw_latency", obs_lat, 1);
    check("fw_ad", last_wr_ad, 10'h004);
    check("fw_din", last_wr_din, 32'hDEADBEEF);
    txn(BASE + 32'h010, 32'h0, 4'h0, 1'b0);
    check("rd_latency", obs_lat, 2);
    check("rd_data", last_ready_data, 32'hDEADBEEF);
    txn(BASE + 32'h011, 32'h0000AA00, 4'b0010, 1'b0);
    check("pw_latency", obs_lat, 3);
    check("pw_din", last_wr_din, 32'hDEADAAEF);
    txn(BASE + 32'h013, 32'h0, 4'h0, 1'b0);
    check("pw_readback", last_ready_data, 32'hDEADAAEF);

    // Misses never touch the RAM or complete.
    miss(32'h0000_2000, 10);
    miss(32'h0000_0010, 3);
    txn(BASE + 32'hFFC, 32'h1234_5678, 4'hF, 1'b0);
    check("top_word_ad", last_wr_ad, 10'h3FF);

    // Reset during the RMW write cycle abandons the write.
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h010;
    mem_wdata = 32'h0077_0000;
    mem_wstrb = 4'b0100;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rmw_wre_before_rst", ram_wre, 1'b1);
    check("rmw_din_before_rst", ram_din, 32'hDE77AAEF);
    #1 resetn = 1'b0;
    tail_rdata = '0;
    #1;
    check("async_rst_ce", ram_ce, 1'b0);
    check("async_rst_wre", ram_wre, 1'b0);
    check("async_rst_ad", ram_ad, 10'h0);
    check("async_rst_din", ram_din, 32'h0);
    check("async_rst_ready", mem_ready, 1'b0);
    check("async_rst_rdata", mem_rdata, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    txn(BASE + 32'h010, 32'h0, 4'h0, 1'b0);
    check("post_rst_latency", obs_lat, 2);
    check("post_rst_readback", last_ready_data, 32'hDEADAAEF);

    // Valid held through ACK, then back-to-back reads.
    txn(BASE + 32'h000, 32'hA5A5_0000, 4'hF, 1'b1);
    txn(BASE + 32'h004, 32'h0000_5A5A, 4'hF, 1'b1);
    rc0 = ready_cnt;
    txn(BASE + 32'h000, 32'h0, 4'h0, 1'b1);
    check("b2b_rd0", last_ready_data, 32'hA5A5_0000);
    txn(BASE + 32'h004, 32'h0, 4'h0, 1'b1);
    check("b2b_rd1", last_ready_data, 32'h0000_5A5A);
    check("b2b_latency", obs_lat, 2);
    check("b2b_pulses", ready_cnt - rc0, 2);
    mem_valid = 1'b0;

    // Randomized traffic checked by the compare process.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        a = $urandom;
        if (a[31:12] == BASE[31:12]) a[13] = ~a[13];
        miss(a, $urandom_range(1, 4));
      end else begin
        a = BASE;
        if (pick < 7) a[5:2] = 4'($urandom_range(0, 15));
        else          a[11:2] = 10'($urandom);
        a[1:0] = 2'($urandom);
        case ($urandom_range(0, 2))
          0:       s = 4'h0;
          1:       s = 4'hF;
          default: s = 4'($urandom);
        endcase
        txn(a, $urandom, s, 1'($urandom));
        if ($urandom_range(0, 2) != 0) begin
          mem_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end
    mem_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pending_writes", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
